// File: rtl/ov7670_pkg.sv
// Shared constants, state encoding and frame helper for the OV7670 SCCB configuration path.
package ov7670_pkg;

  localparam logic [7:0]  SCCB_ID_WRITE = 8'h42;
  localparam logic [15:0] ROM_END       = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY     = 16'hFFF0;

  localparam logic [7:0] COM7   = 8'h12;
  localparam logic [7:0] CLKRC  = 8'h11;
  localparam logic [7:0] COM15  = 8'h40;
  localparam logic [7:0] TSLB   = 8'h3A;
  localparam logic [7:0] COM13  = 8'h3D;
  localparam logic [7:0] RGB444 = 8'h8C;
  localparam logic [7:0] COM3   = 8'h0C;
  localparam logic [7:0] COM14  = 8'h3E;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_BIT   = 3'd3,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5,
    ST_DELAY = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  // ACK slots carry 1 so the shifter releases SIOD there without extra gating.
  function automatic logic [26:0] sccb_frame(input logic [15:0] ent);
    return {SCCB_ID_WRITE, 1'b1, ent[15:8], 1'b1, ent[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Register table ROM: {reg_addr, reg_data} per index, optional caller-supplied table.
// Latency: 1 cycle (synchronous read).
// Backpressure: none, read every cycle.
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int           TBL_LEN = 0,
  parameter logic [255:0] TBL     = '0
) (
  input  logic        clk_50,
  input  logic [7:0]  idx,
  output logic [15:0] entry
);

  logic [15:0] rom_dat;

  always_comb begin
    rom_dat = ROM_END;
    case (idx)
      8'd0:    rom_dat = {COM7, 8'h80};
      8'd1:    rom_dat = ROM_DELAY;
      8'd2:    rom_dat = {COM7, 8'h14};
      8'd3:    rom_dat = {COM15, 8'hD0};
      8'd4:    rom_dat = {CLKRC, 8'h01};
      8'd5:    rom_dat = {TSLB, 8'h04};
      8'd6:    rom_dat = {COM13, 8'hC0};
      8'd7:    rom_dat = {RGB444, 8'h00};
      8'd8:    rom_dat = {COM3, 8'h00};
      8'd9:    rom_dat = {COM14, 8'h00};
      default: rom_dat = ROM_END;
    endcase
    // A non-empty override table replaces the built-in one; past its end reads as end marker.
    if (TBL_LEN > 0)
      rom_dat = (int'(idx) < TBL_LEN) ? TBL[{idx[3:0], 4'b0000} +: 16] : ROM_END;
  end

  always_ff @(posedge clk_50) entry <= rom_dat;

endmodule

// File: rtl/ov7670_sccb_config.sv
// Walks the register ROM and writes each entry to the OV7670 over SCCB, then raises done.
// Latency: one write = 120 quarter ticks + 2 fetch cycles; done 1 cycle after end-marker fetch.
// Backpressure: none; go is ignored while busy.
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int           CLK_HZ   = 50_000_000,
  parameter int           SCCB_HZ  = 100_000,
  parameter int           DELAY_MS = 10,
  parameter int           TBL_LEN  = 0,
  parameter logic [255:0] TBL      = '0
) (
  input  logic clk_50,
  input  logic reset,
  input  logic go,
  output logic sioc,
  output logic siod_oe,
  output logic busy,
  output logic done
);

  localparam int DIV       = CLK_HZ / (4 * SCCB_HZ);
  localparam int DELAY_CYC = DELAY_MS * (CLK_HZ / 1000);

  state_t      state, state_nxt;
  logic [7:0]  idx;
  logic [15:0] entry;
  logic        fetch_ph;
  logic [15:0] tick_cnt;
  logic        tick;
  logic [1:0]  qtr;
  logic [4:0]  bit_cnt;
  logic [26:0] shreg;
  logic [31:0] dly_cnt;
  logic        sioc_nxt, oe_nxt;
  logic        enter_start, enter_delay;

  ov7670_reg_rom #(.TBL_LEN(TBL_LEN), .TBL(TBL)) u_rom (
    .clk_50 (clk_50),
    .idx    (idx),
    .entry  (entry)
  );

  assign tick        = (tick_cnt == 16'(DIV - 1));
  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign done        = (state == ST_DONE);
  assign enter_start = (state_nxt == ST_START) && (state != ST_START);
  assign enter_delay = (state_nxt == ST_DELAY) && (state != ST_DELAY);

  always_comb begin
    state_nxt = state;
    sioc_nxt  = 1'b1;
    oe_nxt    = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (fetch_ph) begin
          if (entry == ROM_END || idx == 8'hFF) state_nxt = ST_DONE;
          else if (entry == ROM_DELAY)          state_nxt = ST_DELAY;
          else                                  state_nxt = ST_START;
        end
      end
      ST_START: begin
        sioc_nxt = ~qtr[1];
        oe_nxt   = (qtr != 2'd0);
        if (tick && qtr == 2'd3) state_nxt = ST_BIT;
      end
      ST_BIT: begin
        sioc_nxt = qtr[1];
        oe_nxt   = ~shreg[26];
        if (tick && qtr == 2'd3 && bit_cnt == 5'd26) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        sioc_nxt = (qtr != 2'd0);
        oe_nxt   = ~qtr[1];
        if (tick && qtr == 2'd3) state_nxt = ST_GAP;
      end
      ST_GAP:   if (tick && qtr == 2'd3) state_nxt = ST_FETCH;
      ST_DELAY: if (dly_cnt == 32'(DELAY_CYC - 1)) state_nxt = ST_FETCH;
      ST_DONE:  if (go) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Bus pins are registered so SIOC/SIOD never glitch on state decode.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sioc     <= 1'b1;
      siod_oe  <= 1'b0;
      idx      <= '0;
      fetch_ph <= 1'b0;
      tick_cnt <= '0;
      qtr      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      dly_cnt  <= '0;
    end else begin
      sioc     <= sioc_nxt;
      siod_oe  <= oe_nxt;
      fetch_ph <= (state == ST_FETCH);

      if (enter_start || enter_delay || tick) tick_cnt <= '0;
      else                                    tick_cnt <= tick_cnt + 16'd1;

      if (enter_start) begin
        qtr     <= '0;
        bit_cnt <= '0;
        shreg   <= sccb_frame(entry);
      end else if (tick) begin
        qtr <= qtr + 2'd1;
        if (state == ST_BIT && qtr == 2'd3) begin
          bit_cnt <= bit_cnt + 5'd1;
          shreg   <= {shreg[25:0], 1'b0};
        end
      end

      dly_cnt <= (state == ST_DELAY) ? dly_cnt + 32'd1 : '0;

      if (state == ST_DONE && go)
        idx <= '0;
      else if ((state == ST_GAP || state == ST_DELAY) && state_nxt == ST_FETCH)
        idx <= idx + 8'd1;
    end
  end

endmodule
